// File: rtl/hdc_pkg.sv
// rtl/hdc_pkg.sv - shared constants and types for the HDC bundling controller
package hdc_pkg;

    localparam int HDC_D  = 64;
    localparam int HDC_W  = 4;
    localparam int HDC_CW = 8;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DRAIN,
        THRESH,
        DONE
    } state_t;

    typedef logic [HDC_CW-1:0] lane_cnt_t;

endpackage

// File: rtl/hdc_bundle_acc.sv
// rtl/hdc_bundle_acc.sv - per-lane saturating vote counters with majority threshold
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous clear of all counters
//   en_i       : add inc_i to the counters this cycle
//   inc_i      : one increment bit per lane
//   n_i        : job length used as the majority reference
//   maj_o      : strict-majority vector, lane j = (2*cnt[j] > n_i)
module hdc_bundle_acc
    import hdc_pkg::*;
#(
    parameter int D  = HDC_D,
    parameter int CW = HDC_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [D-1:0]  inc_i,
    input  logic [CW-1:0] n_i,
    output logic [D-1:0]  maj_o
);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] cnt_q [D];
    logic [CW-1:0] cnt_d [D];

    always_comb begin
        for (int j = 0; j < D; j++) begin
            cnt_d[j] = cnt_q[j];
            if (clr_i) begin
                cnt_d[j] = '0;
            end else if (en_i && inc_i[j] && (cnt_q[j] != CNT_MAX)) begin
                cnt_d[j] = cnt_q[j] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < D; j++) begin
                cnt_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < D; j++) begin
                cnt_q[j] <= cnt_d[j];
            end
        end
    end

    // Compare 2*cnt against N at CW+1 bits so the doubling never overflows;
    // a tie is not a majority.
    always_comb begin
        for (int j = 0; j < D; j++) begin
            maj_o[j] = ({cnt_q[j], 1'b0} > {1'b0, n_i});
        end
    end

endmodule

// File: rtl/hdc_bundle_ctrl.sv
// rtl/hdc_bundle_ctrl.sv - sequences a sample burst through the unary HV datapath and bundles the result
//   clk, rst_n          : clock, async active-low reset
//   start, num_samples  : job request (IDLE only) and its length N
//   busy                : high outside IDLE
//   s_valid/s_ready     : sample input handshake carrying s_sob, s_hog
//   dp_sob, dp_hog      : registered sample driven into the datapath
//   dp_hv               : HV returned by the datapath DP_LAT cycles later
//   hv_valid/hv_ready   : bundled HV output handshake carrying hv_out
module hdc_bundle_ctrl
    import hdc_pkg::*;
#(
    parameter int D      = HDC_D,
    parameter int W      = HDC_W,
    parameter int CW     = HDC_CW,
    parameter int DP_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [CW-1:0]   num_samples,
    output logic            busy,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [D*W-1:0]  s_sob,
    input  logic [W-1:0]    s_hog,
    output logic [D*W-1:0]  dp_sob,
    output logic [W-1:0]    dp_hog,
    input  logic [D-1:0]    dp_hv,
    output logic            hv_valid,
    input  logic            hv_ready,
    output logic [D-1:0]    hv_out
);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t          state_q, state_d;
    logic [CW-1:0]   n_q, n_d;
    logic [CW-1:0]   issued_q, issued_d;
    logic [CW-1:0]   accum_q, accum_d;
    logic [CW-1:0]   issued_inc, accum_inc;
    logic            s_ready_q, s_ready_d;
    logic            hv_valid_q, hv_valid_d;
    logic [D-1:0]    hv_out_q, hv_out_d;
    logic [D*W-1:0]  dp_sob_q, dp_sob_d;
    logic [W-1:0]    dp_hog_q, dp_hog_d;
    // Bit k set means a sample accepted k+1 edges ago is in flight; the tail
    // bit lines up with dp_hv for that sample.
    logic [DP_LAT:0] vpipe_q, vpipe_d;
    logic            accept, acc_en, cnt_clr;
    logic [D-1:0]    maj;

    assign accept     = (state_q == COLLECT) && s_valid && s_ready_q;
    assign acc_en     = vpipe_q[DP_LAT] && ((state_q == COLLECT) || (state_q == DRAIN));
    assign issued_inc = issued_q + CNT_ONE;
    assign accum_inc  = acc_en ? (accum_q + CNT_ONE) : accum_q;
    assign cnt_clr    = (state_q == IDLE) && start && (num_samples != '0);

    hdc_bundle_acc #(
        .D  (D),
        .CW (CW)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .en_i  (acc_en),
        .inc_i (dp_hv),
        .n_i   (n_q),
        .maj_o (maj)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_samples != '0) ? COLLECT : DONE;
                end
            end
            COLLECT: begin
                if (issued_q == n_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (accum_inc == n_q) begin
                    state_d = THRESH;
                end
            end
            THRESH: state_d = DONE;
            DONE: begin
                if (hv_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        n_d        = n_q;
        issued_d   = issued_q;
        accum_d    = accum_inc;
        s_ready_d  = s_ready_q;
        hv_valid_d = hv_valid_q;
        hv_out_d   = hv_out_q;
        dp_sob_d   = dp_sob_q;
        dp_hog_d   = dp_hog_q;
        vpipe_d    = vpipe_q << 1;
        vpipe_d[0] = accept;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d      = num_samples;
                    issued_d = '0;
                    accum_d  = '0;
                    if (num_samples != '0) begin
                        s_ready_d = 1'b1;
                    end else begin
                        hv_out_d   = '0;
                        hv_valid_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    dp_sob_d  = s_sob;
                    dp_hog_d  = s_hog;
                    issued_d  = issued_inc;
                    s_ready_d = (issued_inc != n_q);
                end
            end
            THRESH: begin
                hv_out_d   = maj;
                hv_valid_d = 1'b1;
            end
            DONE: begin
                if (hv_ready) begin
                    hv_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q        <= '0;
            issued_q   <= '0;
            accum_q    <= '0;
            s_ready_q  <= 1'b0;
            hv_valid_q <= 1'b0;
            hv_out_q   <= '0;
            dp_sob_q   <= '0;
            dp_hog_q   <= '0;
            vpipe_q    <= '0;
        end else begin
            n_q        <= n_d;
            issued_q   <= issued_d;
            accum_q    <= accum_d;
            s_ready_q  <= s_ready_d;
            hv_valid_q <= hv_valid_d;
            hv_out_q   <= hv_out_d;
            dp_sob_q   <= dp_sob_d;
            dp_hog_q   <= dp_hog_d;
            vpipe_q    <= vpipe_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign s_ready  = s_ready_q;
    assign hv_valid = hv_valid_q;
    assign hv_out   = hv_out_q;
    assign dp_sob   = dp_sob_q;
    assign dp_hog   = dp_hog_q;

endmodule

// File: doc/hdc_bundle_ctrl.md
Name: hdc_bundle_ctrl

Overview:
Sequencer and bundler for the 64-lane unary HV datapath (unary generators feeding hv_generator lanes).
- Accepts a burst of N feature samples (64 sob values plus one hog value each) over a valid/ready handshake and drives them into the datapath one per cycle.
- Accumulates each returned 64-bit HV into per-lane counters.
- After N samples, emits the majority-bundled binary HV on a valid/ready output handshake.

Parameters:
D, 64, HV dimension (number of lanes)
W, 4, sob/hog value width (unary length 2^W)
CW, 8, per-lane counter width and num_samples width
DP_LAT, 1, datapath register latency from dp_sob/dp_hog to dp_hv

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a bundling job; sampled only in IDLE
num_samples  in  CW  job length N; latched on accepted start
busy  out  1  high in every state except IDLE
s_valid  in  1  input sample valid
s_ready  out  1  controller can accept a sample
s_sob  in  D*W  packed sob values; lane j at [j*W +: W]
s_hog  in  W  hog value for this sample
dp_sob  out  D*W  registered sob to datapath
dp_hog  out  W  registered hog to datapath
dp_hv  in  D  HV bits returned by datapath
hv_valid  out  1  bundled HV available
hv_ready  in  1  consumer accepts hv_out
hv_out  out  D  bundled HV

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, s_ready, hv_valid=0; hv_out, dp_sob, dp_hog, lane counters, issue/accum counters, valid pipe all 0. Reset mid-job aborts the job with no output.
- States: IDLE, COLLECT, DRAIN, THRESH, DONE.
- IDLE:
  - start=1 and num_samples!=0: latch N, clear counters, go to COLLECT.
  - start=1 and num_samples=0: hv_out=0, go to DONE.
  - start in any other state is ignored.
- COLLECT:
  - s_ready=1 while issued<N. It is a registered output and deasserts on the edge where issued reaches N.
  - Accept on s_valid&&s_ready: on that edge, dp_sob<=s_sob, dp_hog<=s_hog, issued++. A bubble is pushed into the valid pipe when no sample is accepted.
  - When issued==N, go to DRAIN; s_ready=0.
- Valid pipe:
  - Depth DP_LAT+1, tracking in-flight samples.
  - dp_hv is sampled DP_LAT+1 edges after the accepting edge.
  - Back-to-back accepts give one accumulate per cycle; gaps propagate as bubbles.
- Accumulate (pipe tail valid): for each lane j, cnt[j] += dp_hv[j], saturating at 2^CW-1; accum++.
  - Accumulation proceeds in COLLECT and DRAIN.
- DRAIN: on the edge where accum reaches N, go to THRESH.
- THRESH: one cycle. hv_out[j] <= ({cnt[j],1'b0} > {1'b0,N}), computed at CW+1 bits. Strict majority; a tie gives 0. Set hv_valid=1 and go to DONE.
- DONE:
  - hv_valid=1 and hv_out is held stable until hv_ready=1.
  - On handshake: hv_valid<=0, go to IDLE. hv_out keeps its value until the next THRESH.
- Latency: hv_valid rises DP_LAT+2 edges after the edge accepting the last sample (3 edges with default DP_LAT).
- dp_sob/dp_hog hold their last value when no sample is accepted.
- A job of N samples needs at least N+DP_LAT+3 cycles.

Decomposition:
- Package hdc_pkg:
  - Constants HDC_D=64, HDC_W=4, HDC_CW=8.
  - Typedef state_t enum {IDLE, COLLECT, DRAIN, THRESH, DONE}.
  - Typedef lane_cnt_t logic [HDC_CW-1:0].
- One sub-module, hdc_bundle_acc:
  - Array of D saturating counters with synchronous clear, enable, and D-bit increment vector.
  - Outputs the majority vector for a given N (threshold logic).
- FSM, handshakes and valid pipe stay in hdc_bundle_ctrl.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> busy=0, s_ready=0, hv_valid=0, hv_out=0, dp_sob=0. Release -> IDLE. Assert rst_n=0 mid-COLLECT -> all outputs 0 immediately, no hv_valid afterwards.
- N=1, every sob lane=5, hog=3 (datapath model: hv[j]=sob[j]>hog) -> hv_valid exactly 3 edges after accept, hv_out=64'hFFFF_FFFF_FFFF_FFFF. Repeat with sob=2, hog=3 -> hv_out=0.
- N=3, lane0 true in 2 of 3 samples, lane1 true in 1 of 3, other lanes 0 -> hv_out=64'h1.
- N=4, lane5 true in exactly 2 of 4 (tie), lane6 in 3 of 4 -> hv_out=64'h40.
- N=5 with s_valid gaps (pattern 1,0,0,1,1,0,1,1); hold hv_ready=0 for 6 cycles; pulse start during DONE -> exactly 5 accepts, hv_out stable while waiting, start ignored, IDLE after handshake.
- start with num_samples=0 -> DONE next edge, hv_out=0, s_ready never asserted. Separately, CW=3 build with N=7, all lanes true -> counters reach 7 without wrap, hv_out all ones.
